// File: rtl/ntt_ctrl_pkg.sv
// Shared control types and defaults for the NTT stage sequencer.
// Latency: none (declarations only); backpressure: n/a.
package ntt_ctrl_pkg;

    localparam int NUM_STAGE_DEF = 3;
    localparam int BU_TOTAL_DEF  = 256;
    localparam int GRP_SHIFT_DEF = 4;
    localparam int IT_DEPTH_W    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // log2 of the group count for a stage, saturated so groups never exceed the butterfly count
    function automatic int grp_log2(input int stage, input int shift, input int log2_total);
        int v;
        v = stage * shift;
        return (v > log2_total) ? log2_total : v;
    endfunction

endpackage

// File: rtl/ntt_grp_counter.sv
// Butterfly/group index counter: bu_idx wraps at a run-time bound, grp_idx advances on each wrap.
// Latency: indices update one cycle after inc_i; backpressure: none, counts whenever inc_i is high.
module ntt_grp_counter
    import ntt_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] wrap_bound_i,
    output logic [CNT_W-1:0] bu_idx_o,
    output logic [CNT_W-1:0] grp_idx_o
);

    logic [CNT_W-1:0] bu_q, bu_d;
    logic [CNT_W-1:0] grp_q, grp_d;

    always_comb begin
        bu_d  = bu_q;
        grp_d = grp_q;
        if (clr_i) begin
            bu_d  = '0;
            grp_d = '0;
        end else if (inc_i) begin
            if (bu_q == wrap_bound_i) begin
                bu_d  = '0;
                grp_d = grp_q + CNT_W'(1);
            end else begin
                bu_d  = bu_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bu_q  <= '0;
            grp_q <= '0;
        end else begin
            bu_q  <= bu_d;
            grp_q <= grp_d;
        end
    end

    assign bu_idx_o  = bu_q;
    assign grp_idx_o = grp_q;

endmodule

// File: rtl/ntt_stage_sequencer.sv
// NTT stage sequencer: twiddle init, per-stage butterfly issue, drain of in-flight results.
// Latency: r_en/tf_ren/w_en/ntt_en are combinational; issue stalls while issue_rdy is low.
module ntt_stage_sequencer
    import ntt_ctrl_pkg::*;
#(
    parameter int NUM_STAGE   = NUM_STAGE_DEF,
    parameter int BU_TOTAL    = BU_TOTAL_DEF,
    parameter int GRP_SHIFT   = GRP_SHIFT_DEF,
    parameter int INIT_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  inv,
    input  logic                  issue_rdy,
    input  logic                  rd_valid,
    input  logic                  bu_valid,
    output logic                  tf_init,
    output logic                  tf_ren,
    output logic                  agu_en,
    output logic                  r_en,
    output logic                  w_en,
    output logic                  ntt_en,
    output logic [IT_DEPTH_W-1:0] it_depth,
    output logic [IT_DEPTH_W-1:0] stage_idx,
    output logic [CNT_W-1:0]      grp_idx,
    output logic [CNT_W-1:0]      bu_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int                    LOG2_BU    = $clog2(BU_TOTAL);
    localparam int                    ISS_W      = CNT_W + 1;
    localparam logic [ISS_W-1:0]      ISS_TOTAL  = ISS_W'(BU_TOTAL);
    localparam logic [ISS_W-1:0]      ISS_LAST   = ISS_W'(BU_TOTAL - 1);
    localparam logic [IT_DEPTH_W-1:0] LAST_STAGE = IT_DEPTH_W'(NUM_STAGE - 1);
    localparam logic [CNT_W-1:0]      INIT_LAST  = CNT_W'(INIT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
    logic [ISS_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [IT_DEPTH_W-1:0]   stage_q, stage_d;
    logic                    inv_q, inv_d;
    logic                    err_q, err_d;
    logic                    issue;
    logic                    grp_clr;
    logic                    drain_empty;
    logic [CNT_W-1:0]        wrap_bound;

    assign drain_empty = (inflight_q == '0);
    assign wrap_bound  = CNT_W'((BU_TOTAL >> grp_log2(int'(stage_q), GRP_SHIFT, LOG2_BU)) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_INIT;
            ST_INIT:  if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
            ST_RUN:   if (issue && issue_cnt_q == ISS_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_empty) state_d = (stage_q < LAST_STAGE) ? ST_RUN : ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tf_init = (state_q == ST_INIT);
        agu_en  = (state_q == ST_RUN) && (issue_cnt_q < ISS_TOTAL);
        issue   = agu_en && issue_rdy;
        r_en    = issue;
        tf_ren  = issue;
        w_en    = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && bu_valid;
        ntt_en  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && rd_valid;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
    end

    // A write with nothing outstanding, or an increment at full scale, flags err and leaves inflight alone
    always_comb begin
        init_cnt_d  = init_cnt_q;
        issue_cnt_d = issue_cnt_q;
        inflight_d  = inflight_q;
        stage_d     = stage_q;
        inv_d       = inv_q;
        err_d       = err_q;
        grp_clr     = 1'b0;

        if (w_en && drain_empty) begin
            err_d = 1'b1;
        end else if (r_en && !w_en) begin
            if (inflight_q == '1) err_d = 1'b1;
            else                  inflight_d = inflight_q + CNT_W'(1);
        end else if (w_en && !r_en) begin
            inflight_d = inflight_q - CNT_W'(1);
        end

        if (issue) issue_cnt_d = issue_cnt_q + ISS_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    init_cnt_d  = '0;
                    issue_cnt_d = '0;
                    inflight_d  = '0;
                    stage_d     = '0;
                    inv_d       = inv;
                    err_d       = 1'b0;
                    grp_clr     = 1'b1;
                end
            end
            ST_INIT:  init_cnt_d = init_cnt_q + CNT_W'(1);
            ST_DRAIN: begin
                if (drain_empty && stage_q < LAST_STAGE) begin
                    stage_d     = stage_q + IT_DEPTH_W'(1);
                    issue_cnt_d = '0;
                    grp_clr     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt_q  <= '0;
            issue_cnt_q <= '0;
            inflight_q  <= '0;
            stage_q     <= '0;
            inv_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            stage_q     <= stage_d;
            inv_q       <= inv_d;
            err_q       <= err_d;
        end
    end

    ntt_grp_counter #(
        .CNT_W (CNT_W)
    ) u_grp_counter (
        .clk          (clk),
        .rst          (rst),
        .inc_i        (issue),
        .clr_i        (grp_clr),
        .wrap_bound_i (wrap_bound),
        .bu_idx_o     (bu_idx),
        .grp_idx_o    (grp_idx)
    );

    assign stage_idx = stage_q;
    assign it_depth  = inv_q ? (LAST_STAGE - stage_q) : stage_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Bench for ntt_stage_sequencer: randomized issue_rdy, 3-cycle memory/butterfly responder,
// transaction-level reference model of phases, issue order and the outstanding-result count.
module tb_ntt_stage_sequencer;

    localparam int NS = 3;
    localparam int BT = 16;
    localparam int GS = 2;
    localparam int IC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst, start, inv, issue_rdy, rd_valid, bu_valid;
    logic          tf_init, tf_ren, agu_en, r_en, w_en, ntt_en, busy, done, err;
    logic [2:0]    it_depth, stage_idx;
    logic [CW-1:0] grp_idx, bu_idx;

    ntt_stage_sequencer #(
        .NUM_STAGE   (NS),
        .BU_TOTAL    (BT),
        .GRP_SHIFT   (GS),
        .INIT_CYCLES (IC),
        .CNT_W       (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inv       (inv),
        .issue_rdy (issue_rdy),
        .rd_valid  (rd_valid),
        .bu_valid  (bu_valid),
        .tf_init   (tf_init),
        .tf_ren    (tf_ren),
        .agu_en    (agu_en),
        .r_en      (r_en),
        .w_en      (w_en),
        .ntt_en    (ntt_en),
        .it_depth  (it_depth),
        .stage_idx (stage_idx),
        .grp_idx   (grp_idx),
        .bu_idx    (bu_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: phase 0 idle, 1 init, 2 issuing/draining, 3 completion
    int ph = 0, init_left = 0, stage_m = 0, issues_m = 0, inflight_m = 0;
    int cyc = 0, stall_left = 0, tf_cnt = 0, done_cnt = 0, obs_iss = 0;
    bit inv_m = 1'b0, err_m = 1'b0, rd_next = 1'b0;
    int due_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int per_group(input int s);
        int groups;
        groups = 1 << (s * GS);
        if (groups > BT) groups = BT;
        return BT / groups;
    endfunction

    task automatic tick(input bit st, input bit rdy_rand, input int stall_stage,
                        input bit spur, input bit do_rst);
        bit bv, exp_agu, exp_r, exp_w, exp_ntt;
        int iss_pre, infl_pre;
        @(negedge clk);
        rst       = do_rst;
        start     = st;
        issue_rdy = spur ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        rd_valid  = rd_next;
        bv = 1'b0;
        if (!spur && stall_left == 0 && due_q.size() > 0) bv = (due_q[0] <= cyc);
        bu_valid = spur | bv;
        if (do_rst) begin
            ph = 0; stage_m = 0; issues_m = 0; inflight_m = 0;
            err_m = 1'b0; inv_m = 1'b0; stall_left = 0; bv = 1'b0;
            due_q.delete();
        end
        #1;
        exp_agu = (ph == 2) && (issues_m < BT);
        exp_r   = exp_agu && issue_rdy;
        exp_w   = (ph == 2) && bu_valid;
        exp_ntt = (ph == 2) && rd_valid;

        chk("busy",    busy,    ph != 0);
        chk("done",    done,    ph == 3);
        chk("tf_init", tf_init, ph == 1);
        chk("agu_en",  agu_en,  exp_agu);
        chk("r_en",    r_en,    exp_r);
        chk("tf_ren",  tf_ren,  exp_r);
        chk("w_en",    w_en,    exp_w);
        chk("ntt_en",  ntt_en,  exp_ntt);
        chk("err",     err,     err_m);
        if (do_rst) begin
            chk("rst_stage_idx", stage_idx, 0);
            chk("rst_it_depth",  it_depth,  0);
            chk("rst_grp_idx",   grp_idx,   0);
            chk("rst_bu_idx",    bu_idx,    0);
        end
        if (ph == 2) begin
            chk("stage_idx", stage_idx, stage_m);
            chk("it_depth",  it_depth,  inv_m ? (NS - 1 - stage_m) : stage_m);
        end
        if (exp_r && r_en === 1'b1) begin
            chk("grp_idx", grp_idx, issues_m / per_group(stage_m));
            chk("bu_idx",  bu_idx,  issues_m % per_group(stage_m));
        end
        if (r_en === 1'b1) obs_iss++;
        if (tf_init === 1'b1) tf_cnt++;
        if (done === 1'b1) done_cnt++;

        iss_pre  = issues_m;
        infl_pre = inflight_m;
        if (exp_w && inflight_m == 0) err_m = 1'b1;
        else if (exp_r && !exp_w) inflight_m++;
        else if (exp_w && !exp_r) inflight_m--;
        if (bv) void'(due_q.pop_front());
        if (exp_r) begin
            issues_m++;
            due_q.push_back(cyc + 3);
        end
        rd_next = exp_r;
        if (stall_left > 0) stall_left--;
        if (exp_r && issues_m == BT && stage_m == stall_stage) stall_left = 10;

        case (ph)
            0: if (st && !do_rst) begin
                ph = 1; init_left = IC; err_m = 1'b0; inflight_m = 0;
                stage_m = 0; issues_m = 0; inv_m = inv; obs_iss = 0;
            end
            1: begin
                init_left--;
                if (init_left == 0) ph = 2;
            end
            2: if (iss_pre == BT && infl_pre == 0) begin
                chk("issues_per_stage", obs_iss, BT);
                obs_iss = 0;
                if (stage_m < NS - 1) begin
                    stage_m++;
                    issues_m = 0;
                end else begin
                    ph = 3;
                end
            end
            default: ph = 0;
        endcase
        cyc++;
    endtask

    task automatic run_xfer(input bit inv_v, input bit rdy_rand, input int stall_stage,
                            input bit abort, input bit spur_run);
        bit fin, do_rst, spur, spur_done;
        fin = 1'b0;
        spur_done = 1'b0;
        tf_cnt = 0;
        done_cnt = 0;
        inv = inv_v;
        tick(1'b1, rdy_rand, stall_stage, 1'b0, 1'b0);
        for (int n = 0; n < 3000 && !fin; n++) begin
            do_rst = abort && ph == 2 && stage_m == 1 && issues_m == 7;
            spur = 1'b0;
            if (spur_run && ph == 1 && init_left == IC) spur = 1'b1;
            if (spur_run && !spur_done && ph == 2 && stage_m == 0 && issues_m == 0) begin
                spur = 1'b1;
                spur_done = 1'b1;
            end
            tick(1'b0, rdy_rand, stall_stage, spur, do_rst);
            fin = (ph == 0);
        end
        chk("xfer_terminates", fin, 1);
        chk("tf_init_cycles", tf_cnt, IC);
        chk("done_pulses", done_cnt, abort ? 0 : 1);
        tick(1'b0, 1'b0, -1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; inv = 1'b0;
        issue_rdy = 1'b0; rd_valid = 1'b0; bu_valid = 1'b0;

        tick(1'b0, 1'b0, -1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, -1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, -1, 1'b0, 1'b0);
        // spurious result while idle
        tick(1'b0, 1'b0, -1, 1'b1, 1'b0);

        run_xfer(1'b0, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b0,  1, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b0, -1, 1'b1, 1'b0);
        run_xfer(1'b0, 1'b1, -1, 1'b0, 1'b0);
        run_xfer(1'b1, 1'b0, -1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, -1, 1'b0, 1'b0);
        run_xfer(1'b0, 1'b1,  0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
